seven_seg_decoder: RTL and testbench

Receive-side counterpart of the calculator's multiplexed 4-digit seven-segment display driver. Samples the `digit_select` / `led_select` pins, captures each digit once its pattern has settled, and reassembles the shown decimal value into a 14-bit binary number. Used for loopback checking of the display path and as a scoreboard front-end in system benches.

---
 rtl/seven_seg_decoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_seven_seg_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_decoder.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment display.
// Optional: SEVEN_SEG_DECODER_CHANGE_ONLY_EN reports only changed values.
module seven_seg_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**21
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  digit_select,
  input  logic [6:0]  led_select,
  output logic [13:0] number,
  output logic        number_valid,
  output logic        frame_error,
  output logic        display_active
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SET_PRE = SW'(SETTLE_CYCLES - 2);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_PRE = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_CONVERT,
    S_REPORT
  } state_t;

  logic [3:0]      dig_m_q, dig_s_q, dig_p_q;
  logic [6:0]      seg_m_q, seg_s_q, seg_p_q;

  logic [SW-1:0]   stab_q, stab_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  state_t          state_q, state_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0][3:0] code_q, code_d;
  logic [3:0]      ill_q, ill_d;
  logic [13:0]     sum_q, sum_d;
  logic [13:0]     num_q, num_d;
  logic            nv_q, nv_d;
  logic            fe_q, fe_d;
  logic            act_q, act_d;
`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
  logic            first_q, first_d;
`endif

  logic            one_low;
  logic [1:0]      sel;
  logic            changed;
  logic            cap;
  logic            expire;
  logic [4:0]      dec;

  // Active-low {g..a} pattern to {illegal, bcd}; blank reads as 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'b1000000: return 5'd0;
      7'b1111001: return 5'd1;
      7'b0100100: return 5'd2;
      7'b0110000: return 5'd3;
      7'b0011001: return 5'd4;
      7'b0010010: return 5'd5;
      7'b0000010: return 5'd6;
      7'b1111000: return 5'd7;
      7'b0000000: return 5'd8;
      7'b0010000: return 5'd9;
      7'b1111111: return 5'd0;
      default:    return 5'h10;
    endcase
  endfunction

  assign dec = seg_decode(seg_s_q);

  // Two-flop synchronisers plus a one-cycle history for change detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_m_q <= 4'hf;
      dig_s_q <= 4'hf;
      dig_p_q <= 4'hf;
      seg_m_q <= 7'h7f;
      seg_s_q <= 7'h7f;
      seg_p_q <= 7'h7f;
    end else begin
      dig_m_q <= digit_select;
      dig_s_q <= dig_m_q;
      dig_p_q <= dig_s_q;
      seg_m_q <= led_select;
      seg_s_q <= seg_m_q;
      seg_p_q <= seg_s_q;
    end
  end

  // Which digit is lit, and whether exactly one anode is driven.
  always_comb begin
    one_low = 1'b1;
    sel     = 2'd0;
    case (dig_s_q)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  // Settling counter; capture fires on the cycle it reaches its limit.
  always_comb begin
    changed = (dig_s_q != dig_p_q) || (seg_s_q != seg_p_q);
    stab_d  = stab_q;
    cap     = 1'b0;
    if (changed || !one_low) begin
      stab_d = '0;
    end else if (stab_q != SET_MAX) begin
      stab_d = stab_q + 1'b1;
      cap    = (stab_q == SET_PRE);
    end
  end

  // Inactivity timer, restarted by any capture.
  always_comb begin
    tmo_d  = tmo_q;
    expire = 1'b0;
    if (cap) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d  = tmo_q + 1'b1;
      expire = (tmo_q == TMO_PRE);
    end
  end

  // Frame FSM: collect four digits, convert, then report.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    code_d  = code_q;
    ill_d   = ill_q;
    sum_d   = sum_q;
    num_d   = num_q;
    nv_d    = 1'b0;
    fe_d    = 1'b0;
    act_d   = act_q;
`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
    first_d = first_q;
`endif
    unique case (state_q)
      S_COLLECT: begin
        if (cap) begin
          code_d[sel] = dec[3:0];
          ill_d[sel]  = dec[4];
          mask_d[sel] = 1'b1;
          if (mask_d == 4'b1111) begin
            state_d = S_CONVERT;
          end
        end
      end
      S_CONVERT: begin
        sum_d = {10'd0, code_q[3]} * 14'd1000
              + {10'd0, code_q[2]} * 14'd100
              + {10'd0, code_q[1]} * 14'd10
              + {10'd0, code_q[0]};
        mask_d  = '0;
        state_d = S_REPORT;
      end
      S_REPORT: begin
        state_d = S_COLLECT;
        ill_d   = '0;
        if (|ill_q) begin
          fe_d = 1'b1;
        end else begin
`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
          if (first_q || (sum_q != num_q)) begin
            num_d   = sum_q;
            nv_d    = 1'b1;
            first_d = 1'b0;
          end
`else
          num_d = sum_q;
          nv_d  = 1'b1;
`endif
        end
        if (nv_d) begin
          act_d = 1'b1;
        end
      end
      default: state_d = S_COLLECT;
    endcase
    if (expire) begin
      state_d = S_COLLECT;
      mask_d  = '0;
      ill_d   = '0;
      num_d   = num_q;
      nv_d    = 1'b0;
      fe_d    = 1'b0;
      act_d   = 1'b0;
`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
      first_d = 1'b1;
`endif
    end
  end

  // State register for counters, FSM and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stab_q  <= '0;
      tmo_q   <= '0;
      state_q <= S_COLLECT;
      mask_q  <= '0;
      code_q  <= '0;
      ill_q   <= '0;
      sum_q   <= '0;
      num_q   <= '0;
      nv_q    <= 1'b0;
      fe_q    <= 1'b0;
      act_q   <= 1'b0;
`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
      first_q <= 1'b1;
`endif
    end else begin
      stab_q  <= stab_d;
      tmo_q   <= tmo_d;
      state_q <= state_d;
      mask_q  <= mask_d;
      code_q  <= code_d;
      ill_q   <= ill_d;
      sum_q   <= sum_d;
      num_q   <= num_d;
      nv_q    <= nv_d;
      fe_q    <= fe_d;
      act_q   <= act_d;
`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
      first_q <= first_d;
`endif
    end
  end

  assign number         = num_q;
  assign number_valid   = nv_q;
  assign frame_error    = fe_q;
  assign display_active = act_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Bench for seven_seg_decoder: table-driven frames with a
// scoreboard queue of expected reports, plus corner sequences.
module tb_seven_seg_decoder;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 300;
  localparam int HOLD    = 40;
`ifdef SEVEN_SEG_DECODER_CHANGE_ONLY_EN
  localparam bit CHG = 1'b1;
`else
  localparam bit CHG = 1'b0;
`endif

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] IL = 7'b0101010;

  typedef struct {
    logic [3:0][6:0] pat;
    bit              err;
    logic [13:0]     val;
  } vec_t;

  typedef struct {
    bit          err;
    logic [13:0] num;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  digit_select = 4'hf;
  logic [6:0]  led_select = 7'h7f;
  logic [13:0] number;
  logic        number_valid;
  logic        frame_error;
  logic        display_active;

  int          npass = 0;
  int          ntot = 0;
  int          cyc = 0;
  int          t4 = 0;
  int          t_nv = 0;
  int          npulse = 0;
  bit          prev_pulse = 1'b0;
  logic [13:0] m_num = '0;
  bit          m_first = 1'b1;
  exp_t        sbq[$];
  vec_t        tbl[8];

  seven_seg_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .digit_select  (digit_select),
    .led_select    (led_select),
    .number        (number),
    .number_valid  (number_valid),
    .frame_error   (frame_error),
    .display_active(display_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Output monitor: every report pulse is matched to the scoreboard.
  always @(negedge clk) begin
    if (reset_n && (number_valid || frame_error)) begin
      exp_t e;
      chk("exclusive", int'(number_valid && frame_error), 0);
      chk("no_back_to_back", int'(prev_pulse), 0);
      if (number_valid) begin
        npulse++;
        t_nv = cyc;
        chk("active_at_valid", int'(display_active), 1);
      end
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", int'(number), -1);
      end else begin
        e = sbq.pop_front();
        chk("kind_err", int'(frame_error), int'(e.err));
        chk("number", int'(number), int'(e.num));
      end
    end
    prev_pulse = reset_n && (number_valid || frame_error);
  end

  task automatic expect_frame(input bit err, input logic [13:0] val);
    exp_t e;
    if (err) begin
      e.err = 1'b1;
      e.num = m_num;
      sbq.push_back(e);
    end else if (!CHG || m_first || val != m_num) begin
      e.err   = 1'b0;
      e.num   = val;
      m_num   = val;
      m_first = 1'b0;
      sbq.push_back(e);
    end
  endtask

  task automatic drive_digit(input int i, input logic [6:0] p, input int n);
    @(negedge clk);
    digit_select = ~(4'b0001 << i);
    led_select   = p;
    if (i == 3) t4 = cyc;
    repeat (n) @(posedge clk);
  endtask

  task automatic drive_frame(input logic [3:0][6:0] pats);
    for (int i = 0; i < 4; i++) drive_digit(i, pats[i], HOLD);
  endtask

  task automatic run_frame(input string nm, input logic [3:0][6:0] pats,
                           input bit err, input logic [13:0] val);
    expect_frame(err, val);
    drive_frame(pats);
    chk(nm, sbq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{ {BL, BL, P4, P9}, 1'b0, 14'd49   };
    tbl[1] = '{ {P0, P0, IL, P0}, 1'b1, 14'd0    };
    tbl[2] = '{ {P9, P8, P7, P6}, 1'b0, 14'd9876 };
    tbl[3] = '{ {P0, P0, P0, P0}, 1'b0, 14'd0    };
    tbl[4] = '{ {P5, P0, P0, P5}, 1'b0, 14'd5005 };
    tbl[5] = '{ {IL, P1, P2, P3}, 1'b1, 14'd0    };
    tbl[6] = '{ {P8, P0, P8, P0}, 1'b0, 14'd8080 };
    tbl[7] = '{ {BL, BL, BL, BL}, 1'b0, 14'd0    };

    repeat (3) @(negedge clk);
    chk("rst_number", int'(number), 0);
    chk("rst_valid", int'(number_valid), 0);
    chk("rst_ferr", int'(frame_error), 0);
    chk("rst_active", int'(display_active), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Legal frame 1234 with latency from last digit to report.
    run_frame("f1234", {P1, P2, P3, P4}, 1'b0, 14'd1234);
    chk("latency", t_nv - t4, SETTLE + 4);
    chk("active_up", int'(display_active), 1);

    for (int k = 0; k < 8; k++) begin
      run_frame($sformatf("tbl%0d", k), tbl[k].pat, tbl[k].err, tbl[k].val);
    end
    chk("num_after_tbl", int'(number), int'(m_num));

    // Glitching segments on digit 2 must not be captured.
    expect_frame(1'b0, 14'd700);
    drive_digit(0, P0, HOLD);
    drive_digit(1, P0, HOLD);
    for (int g = 0; g < 5; g++) drive_digit(2, (g % 2) ? P3 : P5, 1);
    drive_digit(2, P7, HOLD);
    drive_digit(3, P0, HOLD);
    chk("glitch", sbq.size(), 0);
    chk("glitch_num", int'(number), 700);

    // Timeout: all anodes off long enough drops display_active.
    @(negedge clk);
    digit_select = 4'hf;
    led_select   = 7'h7f;
    repeat (TIMEOUT - 40) @(negedge clk);
    chk("still_active", int'(display_active), 1);
    repeat (45) @(negedge clk);
    chk("timed_out", int'(display_active), 0);
    m_first = 1'b1;
    run_frame("f0042", {P0, P0, P4, P2}, 1'b0, 14'd42);
    chk("active_again", int'(display_active), 1);

    // Reset after three captures discards the partial frame.
    drive_digit(0, P5, HOLD);
    drive_digit(1, P6, HOLD);
    drive_digit(2, P7, HOLD);
    @(negedge clk);
    reset_n      = 1'b0;
    digit_select = 4'hf;
    led_select   = 7'h7f;
    @(negedge clk);
    chk("mid_rst_number", int'(number), 0);
    chk("mid_rst_active", int'(display_active), 0);
    chk("mid_rst_valid", int'(number_valid), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_num   = '0;
    m_first = 1'b1;
    npulse  = 0;
    run_frame("f9999", {P9, P9, P9, P9}, 1'b0, 14'd9999);
    chk("f9999_pulses", npulse, 1);

    // Same value three times in a row.
    npulse = 0;
    for (int r = 0; r < 3; r++) begin
      run_frame("rep1234", {P1, P2, P3, P4}, 1'b0, 14'd1234);
    end
    chk("rep_pulses", npulse, CHG ? 1 : 3);
    chk("rep_number", int'(number), 1234);

    repeat (20) @(negedge clk);
    chk("final_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
